// File: rtl/fetch_sequencer_if.sv
// Bundle between the fetch sequencer and its surroundings: instruction register
// and execute handshake in, fetch/PC/execute controls and status out.
interface fetch_sequencer_if;
  logic [31:0] ir;
  logic        exec_done;
  logic        zero;
  logic        im_cs;
  logic        im_rd;
  logic        im_wr;
  logic        ir_ld;
  logic        pc_inc;
  logic        pc_ld;
  logic [1:0]  pc_sel;
  logic        exec_start;
  logic        link_wr;
  logic        retire;
  logic [15:0] retire_cnt;
  logic        halted;
  logic [2:0]  state;

  modport master (
    input  ir, exec_done, zero,
    output im_cs, im_rd, im_wr, ir_ld, pc_inc, pc_ld, pc_sel, exec_start, link_wr,
    output retire, retire_cnt, halted, state
  );

  modport slave (
    output ir, exec_done, zero,
    input  im_cs, im_rd, im_wr, ir_ld, pc_inc, pc_ld, pc_sel, exec_start, link_wr,
    input  retire, retire_cnt, halted, state
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute sequencing FSM with jump, branch and halt handling and a
// wrapping count of retired instructions.
module fetch_sequencer (
  input logic              clk,
  input logic              rst_n,
  fetch_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StFetch    = 3'd1,
    StDecode   = 3'd2,
    StExecWait = 3'd3,
    StBrWait   = 3'd4,
    StBrTake   = 3'd5,
    StJump     = 3'd6,
    StHalt     = 3'd7
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] retire_cnt_q;
  logic [5:0]  op, funct;
  logic        is_jr, is_jal, is_jump, is_break, is_branch, br_taken;
  logic        retire;

  assign op        = bus.ir[31:26];
  assign funct     = bus.ir[5:0];
  assign is_jr     = (op == 6'h00) && (funct == 6'h08);
  assign is_jal    = (op == 6'h03);
  assign is_jump   = (op == 6'h02) || is_jal || is_jr;
  assign is_break  = (op == 6'h00) && (funct == 6'h0D);
  assign is_branch = (op == 6'h04) || (op == 6'h05);
  assign br_taken  = ((op == 6'h04) && bus.zero) || ((op == 6'h05) && !bus.zero);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    bus.im_cs      = 1'b0;
    bus.im_rd      = 1'b0;
    bus.ir_ld      = 1'b0;
    bus.pc_inc     = 1'b0;
    bus.pc_ld      = 1'b0;
    bus.pc_sel     = 2'd0;
    bus.exec_start = 1'b0;
    bus.link_wr    = 1'b0;
    bus.halted     = 1'b0;
    retire         = 1'b0;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        bus.im_cs  = 1'b1;
        bus.im_rd  = 1'b1;
        bus.ir_ld  = 1'b1;
        bus.pc_inc = 1'b1;
        state_d    = StDecode;
      end
      StDecode: begin
        if (is_jump) begin
          state_d = StJump;
        end else if (is_break) begin
          state_d = StHalt;
        end else begin
          bus.exec_start = 1'b1;
          state_d        = is_branch ? StBrWait : StExecWait;
        end
      end
      StExecWait: begin
        if (bus.exec_done) begin
          retire  = 1'b1;
          state_d = StFetch;
        end
      end
      StBrWait: begin
        // A taken branch retires one cycle later, in BR_TAKE.
        if (bus.exec_done) begin
          if (br_taken) begin
            state_d = StBrTake;
          end else begin
            retire  = 1'b1;
            state_d = StFetch;
          end
        end
      end
      StBrTake: begin
        bus.pc_ld  = 1'b1;
        bus.pc_sel = 2'd0;
        retire     = 1'b1;
        state_d    = StFetch;
      end
      StJump: begin
        bus.pc_ld   = 1'b1;
        bus.pc_sel  = is_jr ? 2'd2 : 2'd1;
        bus.link_wr = is_jal;
        retire      = 1'b1;
        state_d     = StFetch;
      end
      StHalt: bus.halted = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_q <= 16'h0000;
    end else if (retire) begin
      retire_cnt_q <= retire_cnt_q + 16'h0001;
    end
  end

  assign bus.im_wr      = 1'b0;
  assign bus.retire     = retire;
  assign bus.retire_cnt = retire_cnt_q;
  assign bus.state      = state_q;

endmodule
